mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 20 ++
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 8;
    localparam int NUM_CLIENTS = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: with both requests pending, the client not served last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   last,
    output logic                   valid,
    output logic                   idx
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            idx = ~last;
        end else begin
            idx = req[1] & ~req[0];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises single-word read/write transactions from two clients onto one memory port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CLIENTS-1:0]             req,
    input  logic [NUM_CLIENTS-1:0]             we,
    input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS-1:0][DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]             ack,
    output logic [DATA_W-1:0]                  rdata,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_data_in,
    input  logic [DATA_W-1:0]                  mem_data_out,
    output logic                               mem_read,
    output logic                               mem_write,
    output logic                               busy
);

    localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

    arb_state_t state, state_next;
    logic       last_served;
    logic       gnt_idx;
    logic [3:0] rd_cnt;
    logic       pick_valid;
    logic       pick_idx;

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_served),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Client fields are captured only at grant, so later input changes cannot disturb a running access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            gnt_idx     <= 1'b0;
            rd_cnt      <= 4'd0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rdata       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_idx     <= pick_idx;
                        last_served <= pick_idx;
                        mem_addr    <= addr[pick_idx];
                        mem_data_in <= wdata[pick_idx];
                        rd_cnt      <= LAT_INIT;
                    end
                end
                READ: begin
                    if (rd_cnt == 4'd0) begin
                        rdata <= mem_data_out;
                    end else begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ack        = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = we[pick_idx] ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_write  = 1'b1;
                state_next = ACK;
            end
            READ: begin
                mem_read = 1'b1;
                if (rd_cnt == 4'd0) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                ack[gnt_idx] = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with RD_LAT=3: vector table, scoreboard monitor and multi-cycle corner sequences.
module tb_mem_arbiter;

    typedef struct {
        logic       client;
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req;
    logic [1:0]      we;
    logic [1:0][4:0] addr;
    logic [1:0][7:0] wdata;
    logic [1:0]      ack;
    logic [7:0]      rdata;
    logic [4:0]      mem_addr;
    logic [7:0]      mem_data_in;
    logic [7:0]      mem_data_out;
    logic            mem_read;
    logic            mem_write;
    logic            busy;

    logic [7:0] mem [0:31];
    vec_t       exp_q[$];
    vec_t       vecs[10];
    logic [7:0] last_rdata_exp;
    int         checks;
    int         errors;
    int         rd_cycles;
    int         wr_cycles;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Strobe and completion monitor: every ack pops the oldest expected transaction.
    always @(negedge clk) begin
        vec_t item;
        if (!rst_n) begin
            rd_cycles = 0;
            wr_cycles = 0;
        end else begin
            if (mem_read || mem_write) checkOutput("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
            if (mem_write) begin
                wr_cycles++;
                if (exp_q.size() == 0) checkOutput("unexpected_write", 32'd1, 32'd0);
                else begin
                    checkOutput("wr_addr", {27'd0, mem_addr}, {27'd0, exp_q[0].addr});
                    checkOutput("wr_data", {24'd0, mem_data_in}, {24'd0, exp_q[0].wdata});
                end
            end
            if (mem_read) begin
                rd_cycles++;
                if (exp_q.size() == 0) checkOutput("unexpected_read", 32'd1, 32'd0);
                else checkOutput("rd_addr", {27'd0, mem_addr}, {27'd0, exp_q[0].addr});
            end
            if (ack != 2'b00) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ack", {30'd0, ack}, 32'd0);
                end else begin
                    item = exp_q.pop_front();
                    checkOutput("ack_client", {30'd0, ack}, item.client ? 32'd2 : 32'd1);
                    checkOutput("busy_in_ack", {31'd0, busy}, 32'd1);
                    if (item.we) begin
                        checkOutput("wr_len", wr_cycles, 1);
                        checkOutput("rd_len_on_wr", rd_cycles, 0);
                        checkOutput("rdata_hold", {24'd0, rdata}, {24'd0, last_rdata_exp});
                    end else begin
                        checkOutput("rd_len", rd_cycles, 3);
                        checkOutput("wr_len_on_rd", wr_cycles, 0);
                        checkOutput("rdata", {24'd0, rdata}, {24'd0, item.exp_rdata});
                        last_rdata_exp = item.exp_rdata;
                    end
                end
                rd_cycles = 0;
                wr_cycles = 0;
            end
        end
    end

    task automatic waitAck(input logic c, output int n);
        n = 0;
        while (ack[c] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ack[c] !== 1'b1) checkOutput("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        @(posedge clk);
        #1;
        req[v.client]   = 1'b1;
        we[v.client]    = v.we;
        addr[v.client]  = v.addr;
        wdata[v.client] = v.wdata;
        exp_q.push_back(v);
        waitAck(v.client, n);
        checkOutput("latency", n, v.we ? 32'd2 : 32'd4);
        req[v.client] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ack_pulse", {30'd0, ack}, 32'd0);
        checkOutput("addr_hold", {27'd0, mem_addr}, {27'd0, v.addr});
    endtask

    task automatic runHeld(input int n_acks);
        int seen = 0;
        int cyc = 0;
        while (seen < n_acks && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ack != 2'b00) seen++;
        end
        req = 2'b00;
        checkOutput("held_acks", seen, n_acks);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ack"}, {30'd0, ack}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
        checkOutput({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
        checkOutput({tag, "_mem_data_in"}, {24'd0, mem_data_in}, 32'd0);
        checkOutput({tag, "_rdata"}, {24'd0, rdata}, 32'd0);
    endtask

    // Main sequence: reset, vector table, held/changed inputs, reset abort, contention, fairness.
    initial begin
        int n;
        checks = 0;
        errors = 0;
        rd_cycles = 0;
        wr_cycles = 0;
        last_rdata_exp = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        req   = 2'b00;
        we    = 2'b00;
        addr  = '0;
        wdata = '0;

        vecs[0] = '{1'b0, 1'b1, 5'd5,  8'hA5, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 5'd5,  8'h00, 8'hA5};
        vecs[2] = '{1'b0, 1'b1, 5'd0,  8'h00, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 5'd31, 8'hFF, 8'hA5};
        vecs[4] = '{1'b0, 1'b0, 5'd0,  8'h00, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 5'd31, 8'h00, 8'hFF};
        vecs[6] = '{1'b1, 1'b1, 5'd31, 8'h5A, 8'hFF};
        vecs[7] = '{1'b0, 1'b0, 5'd31, 8'h00, 8'h5A};
        vecs[8] = '{1'b0, 1'b1, 5'd1,  8'h3C, 8'h5A};
        vecs[9] = '{1'b1, 1'b0, 5'd1,  8'h00, 8'h3C};

        #1;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Inputs change and req drops right after the grant; the latched write must still land.
        @(posedge clk);
        #1;
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 5'd9; wdata[0] = 8'h99;
        exp_q.push_back('{1'b0, 1'b1, 5'd9, 8'h99, 8'h00});
        @(posedge clk);
        #1;
        req[0] = 1'b0; addr[0] = 5'd10; wdata[0] = 8'h00; we[0] = 1'b0;
        waitAck(1'b0, n);
        @(posedge clk);
        #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd9;
        exp_q.push_back('{1'b1, 1'b0, 5'd9, 8'h00, 8'h99});
        @(posedge clk);
        #1;
        req[1] = 1'b0; addr[1] = 5'd10; we[1] = 1'b1;
        waitAck(1'b1, n);
        @(posedge clk);
        #1;

        // Reset during a read aborts it without an ack.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 5'd5;
        exp_q.push_back('{1'b1, 1'b0, 5'd5, 8'h00, 8'hA5});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("mid_read_strobe", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        exp_q.delete();
        last_rdata_exp = 8'h00;
        req = 2'b00;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("ack_in_reset", {30'd0, ack}, 32'd0);
        end
        rst_n = 1'b1;

        // First contention after reset goes to client 0, then client 1.
        @(posedge clk);
        #1;
        we[0] = 1'b1; addr[0] = 5'd2; wdata[0] = 8'h11;
        we[1] = 1'b0; addr[1] = 5'd5; wdata[1] = 8'h00;
        exp_q.push_back('{1'b0, 1'b1, 5'd2, 8'h11, 8'h00});
        exp_q.push_back('{1'b1, 1'b0, 5'd5, 8'h00, 8'hA5});
        req = 2'b11;
        runHeld(2);
        @(posedge clk);
        #1;

        // Both clients hold req for six transactions: grants alternate 0,1,0,1,0,1.
        we[0] = 1'b1; addr[0] = 5'd8; wdata[0] = 8'h81;
        we[1] = 1'b0; addr[1] = 5'd8; wdata[1] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{1'b0, 1'b1, 5'd8, 8'h81, 8'h00});
            exp_q.push_back('{1'b1, 1'b0, 5'd8, 8'h00, 8'h81});
        end
        req = 2'b11;
        runHeld(6);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
